// File: rtl/program_loader.sv
// Collects a host program into a 16-entry buffer, streams it into a 4-bit
// computer's memory over 16 load cycles, then releases the target from reset.
module program_loader #(
   parameter int         DEPTH   = 16,
   parameter logic [7:0] PAD_INS = 8'h0F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   input  logic [11:0] wr_data,
   input  logic        wr_last,
   output logic        wr_ready,
   input  logic        abort,
   output logic        cpu_rst,
   output logic [3:0]  ins_address,
   output logic [7:0]  ins,
   output logic [3:0]  d_in,
   output logic [4:0]  entry_count,
   output logic        running
);

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_LOAD    = 2'd1;
   localparam logic [1:0] ST_SETTLE  = 2'd2;
   localparam logic [1:0] ST_RUN     = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [3:0]  index_q, index_d;
   logic        mem_we;
   logic [11:0] entry_mem [DEPTH];

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      count_d = count_q;
      index_d = index_q;
      mem_we  = 1'b0;
      if (abort) begin
         state_d = ST_COLLECT;
         count_d = 5'd0;
         index_d = 4'd0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (wr_valid) begin
                  mem_we  = 1'b1;
                  count_d = count_q + 5'd1;
                  if (wr_last || count_q == 5'd15) begin
                     state_d = ST_LOAD;
                     index_d = 4'd0;
                  end
               end
            end
            ST_LOAD: begin
               index_d = index_q + 4'd1;
               if (index_q == 4'd15) state_d = ST_SETTLE;
            end
            ST_SETTLE: state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_COLLECT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q <= ST_COLLECT;
         count_q <= 5'd0;
         index_q <= 4'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         index_q <= index_d;
      end
   end

   // NOTE: the entry buffer is deliberately not reset; entries past entry_count are never read.
   always_ff @(posedge clk) begin
      if (mem_we) entry_mem[count_q[3:0]] <= wr_data;
   end

   // Outputs decode only from registered state, so rst takes effect without a clock.
   always_comb begin
      wr_ready    = (state_q == ST_COLLECT);
      cpu_rst     = (state_q != ST_RUN);
      running     = (state_q == ST_RUN);
      entry_count = count_q;
      ins_address = 4'd0;
      ins         = 8'd0;
      d_in        = 4'd0;
      if (state_q == ST_LOAD) begin
         ins_address = index_q;
         if ({1'b0, index_q} < count_q) begin
            {ins, d_in} = entry_mem[index_q];
         end else begin
            ins = PAD_INS;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed table, multi-cycle corner
// sequences and randomized traffic checked against a program-level model.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic [11:0] wr_data;
   logic        wr_last;
   logic        wr_ready;
   logic        abort;
   logic        cpu_rst;
   logic [3:0]  ins_address;
   logic [7:0]  ins;
   logic [3:0]  d_in;
   logic [4:0]  entry_count;
   logic        running;

   int checks = 0;
   int errors = 0;

   localparam logic [7:0] PAD = 8'h0F;

   always #5 clk = ~clk;

   program_loader #(.DEPTH(16), .PAD_INS(8'h0F)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_last(wr_last), .wr_ready(wr_ready), .abort(abort), .cpu_rst(cpu_rst),
      .ins_address(ins_address), .ins(ins), .d_in(d_in),
      .entry_count(entry_count), .running(running)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: the accepted program plus the number of edges since the final accept.
   logic [11:0] m_prog[$];
   int          m_k;   // -1 while collecting

   function automatic void model_reset();
      m_prog.delete();
      m_k = -1;
   endfunction

   function automatic void model_edge(input logic v, input logic [11:0] d,
                                      input logic l, input logic a);
      if (a) begin
         m_prog.delete();
         m_k = -1;
      end else if (m_k < 0) begin
         if (v) begin
            m_prog.push_back(d);
            if (l || m_prog.size() == 16) m_k = 0;
         end
      end else if (m_k < 17) begin
         m_k++;
      end
   endfunction

   // Packed {wr_ready, cpu_rst, running, entry_count, ins_address, ins, d_in}
   function automatic logic [23:0] model_outs();
      logic [11:0] word;
      logic [3:0]  addr;
      logic        rdy, crst, run;
      rdy  = (m_k < 0);
      crst = (m_k < 17);
      run  = (m_k >= 17);
      addr = 4'd0;
      word = 12'd0;
      if (m_k >= 0 && m_k < 16) begin
         addr = 4'(m_k);
         word = (m_k < m_prog.size()) ? m_prog[m_k] : {PAD, 4'd0};
      end
      return {rdy, crst, run, 5'(m_prog.size()), addr, word};
   endfunction

   function automatic logic [23:0] dut_outs();
      return {wr_ready, cpu_rst, running, entry_count, ins_address, ins, d_in};
   endfunction

   task automatic cycle(input logic v, input logic [11:0] d, input logic l, input logic a);
      wr_valid = v;
      wr_data  = d;
      wr_last  = l;
      abort    = a;
      @(posedge clk);
      model_edge(v, d, l, a);
      #1;
      check("outs_vs_model", 32'(dut_outs()), 32'(model_outs()));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        v;
      logic [11:0] d;
      logic        l;
      logic        a;
      logic        exp_rdy;
      logic [4:0]  exp_cnt;
      logic        exp_crst;
   } vec_t;

   vec_t tbl[9];
   int   n;

   initial begin
      wr_valid = 1'b0; wr_data = 12'd0; wr_last = 1'b0; abort = 1'b0;
      do_reset();

      check("reset_wr_ready", wr_ready, 1'b1);
      check("reset_cpu_rst", cpu_rst, 1'b1);
      check("reset_running", running, 1'b0);
      check("reset_count", entry_count, 5'd0);
      check("reset_addr_data", {ins_address, ins, d_in}, 16'd0);

      // Directed table: gaps, abort alone, abort colliding with wr_last, ignored writes in LOAD.
      tbl[0] = '{1'b1, 12'h160, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1};
      tbl[1] = '{1'b0, 12'h777, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1};
      tbl[2] = '{1'b1, 12'h02A, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1};
      tbl[3] = '{1'b1, 12'h030, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1};
      tbl[4] = '{1'b1, 12'h0B0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1};
      tbl[5] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1};
      tbl[6] = '{1'b1, 12'h0F0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1};
      tbl[7] = '{1'b1, 12'h111, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1};
      tbl[8] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1};
      for (int i = 0; i < 9; i++) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].a);
         check($sformatf("tbl%0d_wr_ready", i), wr_ready, tbl[i].exp_rdy);
         check($sformatf("tbl%0d_count", i), entry_count, tbl[i].exp_cnt);
         check($sformatf("tbl%0d_cpu_rst", i), cpu_rst, tbl[i].exp_crst);
      end

      // Six-entry program, last on the sixth; cpu_rst must fall 17 edges later.
      cycle(1'b1, 12'h160, 1'b0, 1'b0);
      cycle(1'b0, 12'h000, 1'b0, 1'b0);
      cycle(1'b1, 12'h02A, 1'b0, 1'b0);
      cycle(1'b1, 12'h030, 1'b0, 1'b0);
      cycle(1'b1, 12'h0B0, 1'b0, 1'b0);
      cycle(1'b1, 12'h040, 1'b0, 1'b0);
      cycle(1'b1, 12'h0F0, 1'b1, 1'b0);
      check("six_count", entry_count, 5'd6);
      check("six_addr0", {ins_address, ins, d_in}, {4'd0, 12'h160});
      n = 0;
      for (int i = 1; i <= 30; i++) begin
         cycle(1'b1, 12'hABC, 1'b0, 1'b0);
         if (i == 1) check("six_addr1", {ins_address, ins, d_in}, {4'd1, 12'h02A});
         if (i == 6) check("six_pad6", {ins_address, ins, d_in}, {4'd6, 8'h0F, 4'd0});
         if (i == 15) check("six_pad15", {ins_address, ins, d_in}, {4'd15, 8'h0F, 4'd0});
         if (!cpu_rst) begin
            n = i;
            break;
         end
      end
      check("cpu_rst_fall_latency", n, 17);
      check("six_running", running, 1'b1);
      cycle(1'b1, 12'h123, 1'b1, 1'b0);
      check("run_holds_count", entry_count, 5'd6);

      // Asynchronous reset between edges while running.
      #3;
      rst = 1'b1;
      #1;
      check("async_cpu_rst", cpu_rst, 1'b1);
      check("async_running", running, 1'b0);
      check("async_wr_ready", wr_ready, 1'b1);
      check("async_count", entry_count, 5'd0);
      model_reset();
      #2;
      rst = 1'b0;

      // Sixteen entries without wr_last, then abort at load index 7.
      for (int i = 0; i < 16; i++) cycle(1'b1, 12'(i * 37 + 5), 1'b0, 1'b0);
      check("full_count", entry_count, 5'd16);
      check("full_wr_ready", wr_ready, 1'b0);
      for (int i = 0; i < 7; i++) cycle(1'b1, 12'hFFF, 1'b0, 1'b0);
      check("full_addr7", {ins_address, ins, d_in}, {4'd7, 12'(7 * 37 + 5)});
      cycle(1'b0, 12'h000, 1'b0, 1'b1);
      check("abort_cpu_rst", cpu_rst, 1'b1);
      check("abort_count", entry_count, 5'd0);
      check("abort_wr_ready", wr_ready, 1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 1) == 1, 12'($urandom), $urandom_range(0, 5) == 0,
               $urandom_range(0, 60) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
